// File: rtl/irq_aggregator.sv
// -----------------------------------------------------------------------------
// irq_aggregator
//
// Gathers up to 16 peripheral interrupt lines, the interval timer's included,
// into one prioritised interrupt for the Nios II. Each source is either level
// (PENDING follows the synchronised line) or edge (PENDING captures rising
// edges and software triggers and is cleared by write-one-to-clear). A 16-bit
// Avalon-MM slave exposes the control and status registers. readdata is
// registered with one cycle of latency and there is no waitrequest.
//
// Ports:
//   clk         system clock, rising edge
//   reset_n     synchronous active-low reset
//   irq_in      source interrupt lines, active-high, synchronous to clk
//   address     Avalon word address (0..7)
//   chipselect  slave select
//   write_n     active-low write strobe
//   writedata   write data
//   readdata    registered read data, always reflects the previous address
//   irq_out     registered OR of all unmasked pending sources
//   irq_index   registered index of the lowest-numbered active source
//
// Register map:
//   0 PENDING   read, W1C for edge-mode bits
//   1 MASK      read/write
//   2 EDGE_MODE read/write, 1 = edge-captured source
//   3 ACTIVE    read-only, PENDING & MASK
//   4 HIGHEST   read-only, bit15 = any active, bits3:0 = highest index
//   5 RAW       read-only, synchronised irq lines
//   6 SW_SET    write-only, sets edge-mode PENDING bits, reads 0
//   7 OVERFLOW  read, W1C
// -----------------------------------------------------------------------------
module irq_aggregator #(
    parameter int unsigned NUM_IRQ    = 8,
    parameter logic [15:0] RESET_MASK = 16'h0000,
    parameter logic [15:0] RESET_EDGE = 16'h0000
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [NUM_IRQ-1:0] irq_in,
    input  logic [2:0]         address,
    input  logic               chipselect,
    input  logic               write_n,
    input  logic [15:0]        writedata,
    output logic [15:0]        readdata,
    output logic               irq_out,
    output logic [3:0]         irq_index
);

    localparam logic [2:0] ADDR_PENDING  = 3'd0;
    localparam logic [2:0] ADDR_MASK     = 3'd1;
    localparam logic [2:0] ADDR_EDGE     = 3'd2;
    localparam logic [2:0] ADDR_ACTIVE   = 3'd3;
    localparam logic [2:0] ADDR_HIGHEST  = 3'd4;
    localparam logic [2:0] ADDR_RAW      = 3'd5;
    localparam logic [2:0] ADDR_SW_SET   = 3'd6;
    localparam logic [2:0] ADDR_OVERFLOW = 3'd7;

    // Input stage
    logic [NUM_IRQ-1:0] irq_s_q;
    logic [NUM_IRQ-1:0] irq_prev_q;
    logic [NUM_IRQ-1:0] rise;

    // Control / status registers
    logic [NUM_IRQ-1:0] pending_q;
    logic [NUM_IRQ-1:0] pending_d;
    logic [NUM_IRQ-1:0] mask_q;
    logic [NUM_IRQ-1:0] edge_q;
    logic [NUM_IRQ-1:0] overflow_q;
    logic [NUM_IRQ-1:0] overflow_d;

    // Bus decode
    logic               wr_en;
    logic [NUM_IRQ-1:0] wdata;
    logic [NUM_IRQ-1:0] sw_set;
    logic [NUM_IRQ-1:0] pend_clr;
    logic [NUM_IRQ-1:0] ovf_clr;
    logic [NUM_IRQ-1:0] set_ev;
    logic [NUM_IRQ-1:0] ovf_set;

    // Priority / read path
    logic [NUM_IRQ-1:0] active;
    logic               any_active;
    logic [3:0]         idx_next;
    logic [15:0]        rd_mux;

    // Zero-extend a per-source vector to the 16-bit bus.
    function automatic logic [15:0] widen(input logic [NUM_IRQ-1:0] v);
        logic [15:0] r;
        r = '0;
        r[NUM_IRQ-1:0] = v;
        return r;
    endfunction

    // Writedata bits above NUM_IRQ have no register behind them.
    if (NUM_IRQ < 16) begin : g_unused_wdata
        logic unused_wdata;
        assign unused_wdata = ^writedata[15:NUM_IRQ];
    end

    // ---------------------------------------------------------------------
    // Write decode and event terms
    // ---------------------------------------------------------------------
    assign wr_en    = chipselect & ~write_n;
    assign wdata    = writedata[NUM_IRQ-1:0];
    assign sw_set   = (wr_en && address == ADDR_SW_SET)   ? wdata : '0;
    assign pend_clr = (wr_en && address == ADDR_PENDING)  ? wdata : '0;
    assign ovf_clr  = (wr_en && address == ADDR_OVERFLOW) ? wdata : '0;

    assign rise   = irq_s_q & ~irq_prev_q;
    assign set_ev = rise | sw_set;

    // ---------------------------------------------------------------------
    // Pending and overflow next state
    // ---------------------------------------------------------------------
    always_comb begin
        // Level bits track the line. Edge bits: set beats clear beats hold,
        // so an event landing on the same cycle as a W1C is never lost.
        pending_d = (~edge_q & irq_s_q)
                  | ( edge_q & (set_ev | (pending_q & ~pend_clr)));

        // A second event while the first is still unserviced. A same-cycle
        // W1C means the old event was consumed, so that is not an overflow.
        ovf_set    = edge_q & set_ev & pending_q & ~pend_clr;
        overflow_d = ovf_set | (overflow_q & ~ovf_clr);
    end

    // ---------------------------------------------------------------------
    // Priority encoder: lowest index wins
    // ---------------------------------------------------------------------
    assign active     = pending_q & mask_q;
    assign any_active = |active;

    always_comb begin
        idx_next = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (active[i]) begin
                idx_next = 4'(i);
            end
        end
    end

    // ---------------------------------------------------------------------
    // Read mux, registered below regardless of chipselect
    // ---------------------------------------------------------------------
    always_comb begin
        rd_mux = '0;
        unique case (address)
            ADDR_PENDING:  rd_mux = widen(pending_q);
            ADDR_MASK:     rd_mux = widen(mask_q);
            ADDR_EDGE:     rd_mux = widen(edge_q);
            ADDR_ACTIVE:   rd_mux = widen(active);
            ADDR_HIGHEST: begin
                rd_mux[15]  = any_active;
                rd_mux[3:0] = idx_next;
            end
            ADDR_RAW:      rd_mux = widen(irq_s_q);
            ADDR_SW_SET:   rd_mux = '0;
            ADDR_OVERFLOW: rd_mux = widen(overflow_q);
            default:       rd_mux = '0;
        endcase
    end

    // ---------------------------------------------------------------------
    // State
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            irq_s_q    <= '0;
            irq_prev_q <= '0;
            pending_q  <= '0;
            overflow_q <= '0;
            mask_q     <= RESET_MASK[NUM_IRQ-1:0];
            edge_q     <= RESET_EDGE[NUM_IRQ-1:0];
            readdata   <= '0;
            irq_out    <= 1'b0;
            irq_index  <= '0;
        end else begin
            irq_s_q    <= irq_in;
            irq_prev_q <= irq_s_q;
            pending_q  <= pending_d;
            overflow_q <= overflow_d;

            if (wr_en && address == ADDR_MASK) begin
                mask_q <= wdata;
            end
            if (wr_en && address == ADDR_EDGE) begin
                edge_q <= wdata;
            end

            // Read sees pre-write state, so a PENDING read alongside a W1C
            // returns the value before the clear.
            readdata  <= rd_mux;
            irq_out   <= any_active;
            irq_index <= idx_next;
        end
    end

endmodule

// File: tb/tb_irq_aggregator.sv
module tb_irq_aggregator;

    logic        clk;
    logic        reset_n;
    logic [7:0]  irq_in;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [15:0] writedata;
    logic [15:0] readdata;
    logic        irq_out;
    logic [3:0]  irq_index;

    irq_aggregator #(
        .NUM_IRQ    (8),
        .RESET_MASK (16'h0000),
        .RESET_EDGE (16'h0000)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .irq_in     (irq_in),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .irq_out    (irq_out),
        .irq_index  (irq_index)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One cycle of stimulus and what the outputs must show after its edge.
    typedef struct {
        logic [7:0]  irq;
        logic        wr;
        logic [2:0]  addr;
        logic [15:0] wdata;
        logic        chk_rd;
        logic [15:0] exp_rd;
        logic        chk_irq;
        logic        exp_out;
        logic [3:0]  exp_idx;
        string       name;
    } vec_t;

    typedef struct {
        logic        chk_rd;
        logic [15:0] exp_rd;
        logic        chk_irq;
        logic        exp_out;
        logic [3:0]  exp_idx;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    localparam logic N = 1'b0;
    localparam logic Y = 1'b1;

    function automatic vec_t mk(input logic [7:0] irq, input logic wr, input logic [2:0] addr,
                                input logic [15:0] wdata, input logic crd,
                                input logic [15:0] erd, input logic cirq, input logic eout,
                                input logic [3:0] eidx, input string name);
        vec_t v;
        v.irq = irq;     v.wr = wr;         v.addr = addr;   v.wdata = wdata;
        v.chk_rd = crd;  v.exp_rd = erd;    v.chk_irq = cirq;
        v.exp_out = eout; v.exp_idx = eidx; v.name = name;
        return v;
    endfunction

    // Drive one cycle, queue the expectation, compare #1 after the edge.
    task automatic step(input vec_t v);
        exp_t e;
        exp_t got;
        irq_in     = v.irq;
        chipselect = v.wr;
        write_n    = ~v.wr;
        address    = v.addr;
        writedata  = v.wdata;
        e.chk_rd  = v.chk_rd;  e.exp_rd  = v.exp_rd;
        e.chk_irq = v.chk_irq; e.exp_out = v.exp_out; e.exp_idx = v.exp_idx;
        e.name    = v.name;
        sb.push_back(e);
        @(posedge clk);
        #1;
        got = sb.pop_front();
        if (got.chk_rd) begin
            checks++;
            if (readdata !== got.exp_rd) begin
                errors++;
                $display("FAIL %s readdata got %h expected %h", got.name, readdata, got.exp_rd);
            end
        end
        if (got.chk_irq) begin
            checks++;
            if (irq_out !== got.exp_out) begin
                errors++;
                $display("FAIL %s irq_out got %b expected %b", got.name, irq_out, got.exp_out);
            end
            checks++;
            if (irq_index !== got.exp_idx) begin
                errors++;
                $display("FAIL %s irq_index got %0d expected %0d", got.name, irq_index,
                         got.exp_idx);
            end
        end
    endtask

    task automatic wr(input logic [2:0] addr, input logic [15:0] d);
        step(mk(8'h00, Y, addr, d, N, 16'h0, N, 1'b0, 4'd0, "wr"));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            step(mk(8'h00, N, 3'd0, 16'h0, N, 16'h0, N, 1'b0, 4'd0, "idle"));
        end
    endtask

    vec_t tbl[19];

    initial begin
        // Level path and priority, one row per clock.
        tbl[0]  = mk(8'h00, N, 3'd1, 16'h0000, Y, 16'h0000, Y, 1'b0, 4'd0, "rst_mask");
        tbl[1]  = mk(8'h00, N, 3'd2, 16'h0000, Y, 16'h0000, N, 1'b0, 4'd0, "rst_edge");
        tbl[2]  = mk(8'h00, Y, 3'd1, 16'h0004, N, 16'h0000, N, 1'b0, 4'd0, "wr_mask4");
        tbl[3]  = mk(8'h04, N, 3'd1, 16'h0000, Y, 16'h0004, Y, 1'b0, 4'd0, "lvl_mask_rd");
        tbl[4]  = mk(8'h04, N, 3'd5, 16'h0000, Y, 16'h0004, Y, 1'b0, 4'd0, "lvl_raw");
        tbl[5]  = mk(8'h04, N, 3'd0, 16'h0000, Y, 16'h0004, Y, 1'b1, 4'd2, "lvl_rise_n3");
        tbl[6]  = mk(8'h00, N, 3'd3, 16'h0000, Y, 16'h0004, Y, 1'b1, 4'd2, "lvl_active");
        tbl[7]  = mk(8'h00, N, 3'd4, 16'h0000, Y, 16'h8002, Y, 1'b1, 4'd2, "lvl_highest");
        tbl[8]  = mk(8'h00, N, 3'd0, 16'h0000, Y, 16'h0000, Y, 1'b0, 4'd0, "lvl_fall_n3");
        tbl[9]  = mk(8'h28, Y, 3'd1, 16'h00FF, N, 16'h0000, Y, 1'b0, 4'd0, "pri_wr_mask");
        tbl[10] = mk(8'h28, N, 3'd4, 16'h0000, Y, 16'h0000, Y, 1'b0, 4'd0, "pri_empty");
        tbl[11] = mk(8'h28, N, 3'd0, 16'h0000, N, 16'h0000, N, 1'b0, 4'd0, "pri_wait");
        tbl[12] = mk(8'h28, N, 3'd4, 16'h0000, Y, 16'h8003, Y, 1'b1, 4'd3, "pri_idx3");
        tbl[13] = mk(8'h28, Y, 3'd1, 16'h00F7, N, 16'h0000, Y, 1'b1, 4'd3, "pri_unmask3");
        tbl[14] = mk(8'h28, N, 3'd4, 16'h0000, Y, 16'h8005, Y, 1'b1, 4'd5, "pri_idx5");
        tbl[15] = mk(8'h28, N, 3'd3, 16'h0000, Y, 16'h0020, Y, 1'b1, 4'd5, "pri_active");
        tbl[16] = mk(8'h00, Y, 3'd1, 16'h0000, N, 16'h0000, N, 1'b0, 4'd0, "pri_mask0");
        tbl[17] = mk(8'h00, N, 3'd0, 16'h0000, N, 16'h0000, Y, 1'b0, 4'd0, "pri_masked");
        tbl[18] = mk(8'h00, Y, 3'd3, 16'hFFFF, N, 16'h0000, N, 1'b0, 4'd0, "ro_write");

        irq_in = 8'h00; address = 3'd0; chipselect = 1'b0; write_n = 1'b1;
        writedata = 16'h0;

        // Reset with every line high; RAW must still read 0.
        reset_n = 1'b0;
        step(mk(8'hFF, N, 3'd5, 16'h0, N, 16'h0, N, 1'b0, 4'd0, "rst0"));
        step(mk(8'hFF, N, 3'd5, 16'h0, Y, 16'h0000, Y, 1'b0, 4'd0, "rst_hold"));
        reset_n = 1'b1;

        for (int i = 0; i < 19; i++) begin
            step(tbl[i]);
        end
        step(mk(8'h00, N, 3'd3, 16'h0, Y, 16'h0000, N, 1'b0, 4'd0, "ro_ignored"));
        idle(3);

        // Edge capture and W1C
        wr(3'd2, 16'h0001);
        wr(3'd1, 16'h0001);
        step(mk(8'h01, N, 3'd0, 16'h0, N, 16'h0, N, 1'b0, 4'd0, "e_pulse"));
        step(mk(8'h00, N, 3'd0, 16'h0, N, 16'h0, Y, 1'b0, 4'd0, "e_not_yet"));
        step(mk(8'h00, N, 3'd0, 16'h0, Y, 16'h0001, Y, 1'b1, 4'd0, "e_pending"));
        step(mk(8'h00, N, 3'd0, 16'h0, Y, 16'h0001, Y, 1'b1, 4'd0, "e_held"));
        step(mk(8'h00, Y, 3'd0, 16'h0001, Y, 16'h0001, Y, 1'b1, 4'd0, "e_w1c_preclr"));
        step(mk(8'h00, N, 3'd0, 16'h0, Y, 16'h0000, Y, 1'b0, 4'd0, "e_cleared"));
        wr(3'd2, 16'h0000);
        wr(3'd1, 16'h0000);
        idle(3);

        // Overflow, then event colliding with W1C
        wr(3'd2, 16'h0002);
        wr(3'd1, 16'h0002);
        step(mk(8'h02, N, 3'd0, 16'h0, N, 16'h0, N, 1'b0, 4'd0, "o_p1"));
        step(mk(8'h00, N, 3'd0, 16'h0, N, 16'h0, N, 1'b0, 4'd0, "o_p1_lo"));
        step(mk(8'h02, N, 3'd7, 16'h0, Y, 16'h0000, N, 1'b0, 4'd0, "o_no_ovf_yet"));
        step(mk(8'h00, N, 3'd0, 16'h0, N, 16'h0, N, 1'b0, 4'd0, "o_p2_lo"));
        step(mk(8'h00, N, 3'd7, 16'h0, Y, 16'h0002, Y, 1'b1, 4'd1, "o_overflow"));
        step(mk(8'h02, Y, 3'd7, 16'h0002, Y, 16'h0002, N, 1'b0, 4'd0, "o_ovf_w1c"));
        step(mk(8'h00, Y, 3'd0, 16'h0002, Y, 16'h0002, N, 1'b0, 4'd0, "o_collide"));
        step(mk(8'h00, N, 3'd0, 16'h0, Y, 16'h0002, Y, 1'b1, 4'd1, "o_set_wins"));
        step(mk(8'h00, N, 3'd7, 16'h0, Y, 16'h0000, Y, 1'b1, 4'd1, "o_no_new_ovf"));
        wr(3'd0, 16'h0002);
        step(mk(8'h00, N, 3'd0, 16'h0, Y, 16'h0000, N, 1'b0, 4'd0, "o_w1c_plain"));
        wr(3'd2, 16'h0000);
        wr(3'd1, 16'h0000);
        idle(3);

        // Software trigger and edge-to-level switch
        wr(3'd2, 16'h0010);
        wr(3'd1, 16'h0010);
        step(mk(8'h00, Y, 3'd6, 16'h0010, N, 16'h0, Y, 1'b0, 4'd0, "s_trigger"));
        step(mk(8'h00, N, 3'd6, 16'h0, Y, 16'h0000, Y, 1'b1, 4'd4, "s_swset_rd0"));
        step(mk(8'h00, N, 3'd0, 16'h0, Y, 16'h0010, Y, 1'b1, 4'd4, "s_pending"));
        step(mk(8'h00, Y, 3'd2, 16'h0000, N, 16'h0, Y, 1'b1, 4'd4, "s_to_level"));
        step(mk(8'h00, N, 3'd0, 16'h0, Y, 16'h0010, N, 1'b0, 4'd0, "s_still_set"));
        step(mk(8'h00, N, 3'd0, 16'h0, Y, 16'h0000, Y, 1'b0, 4'd0, "s_reloaded"));
        step(mk(8'h00, Y, 3'd6, 16'h0010, N, 16'h0, N, 1'b0, 4'd0, "s_lvl_trigger"));
        step(mk(8'h00, N, 3'd0, 16'h0, Y, 16'h0000, Y, 1'b0, 4'd0, "s_lvl_noeff1"));
        step(mk(8'h00, N, 3'd0, 16'h0, Y, 16'h0000, Y, 1'b0, 4'd0, "s_lvl_noeff2"));

        // Reset mid-operation drops a captured event
        wr(3'd2, 16'h0010);
        wr(3'd6, 16'h0010);
        step(mk(8'h00, N, 3'd0, 16'h0, Y, 16'h0010, Y, 1'b1, 4'd4, "m_pending"));
        reset_n = 1'b0;
        step(mk(8'h00, N, 3'd2, 16'h0, Y, 16'h0000, Y, 1'b0, 4'd0, "m_in_reset"));
        reset_n = 1'b1;
        step(mk(8'h00, N, 3'd0, 16'h0, Y, 16'h0000, Y, 1'b0, 4'd0, "m_pend_gone"));
        step(mk(8'h00, N, 3'd2, 16'h0, Y, 16'h0000, N, 1'b0, 4'd0, "m_edge_rst"));
        step(mk(8'h00, N, 3'd1, 16'h0, Y, 16'h0000, Y, 1'b0, 4'd0, "m_mask_rst"));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/irq_aggregator.md
Name: irq_aggregator

Overview:
- Collects peripheral interrupt lines, including the system interval timer's irq, into one prioritised CPU interrupt.
- Sits directly downstream of the timer and the other peripherals, and upstream of the Nios II interrupt input.
- Exposes a 16-bit Avalon-MM slave for pending, mask, edge-mode, software-trigger and overflow control.
- Read timing matches the timer slave: registered readdata, 1-cycle latency, no waitrequest.

Parameters:
- NUM_IRQ, 8, number of interrupt source inputs (1..16); bits at index >= NUM_IRQ read 0 and ignore writes.
- RESET_MASK, 16'h0000, reset value of the MASK register.
- RESET_EDGE, 16'h0000, reset value of the EDGE_MODE register (1 = edge-captured source).

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset_n  input  1  synchronous, active-low reset, sampled on rising clk.
- irq_in  input  NUM_IRQ  source interrupt lines, active-high, synchronous to clk.
- address  input  3  Avalon word address.
- chipselect  input  1  slave select.
- write_n  input  1  active-low write strobe.
- writedata  input  16  write data.
- readdata  output  16  registered read data.
- irq_out  output  1  registered combined interrupt to the CPU.
- irq_index  output  4  registered index of the highest-priority active source.

Behaviour:
- Reset (reset_n=0 at a clk edge) clears state:
  - readdata=0, irq_out=0, irq_index=0.
  - PENDING=0, OVERFLOW=0, irq_prev=0.
  - MASK=RESET_MASK, EDGE_MODE=RESET_EDGE.
  - Reset mid-operation discards all captured events.
- Input stage: irq_s <= irq_in each cycle; irq_prev <= irq_s.
  - rise = irq_s & ~irq_prev.
- PENDING[i], level mode (EDGE_MODE[i]=0): PENDING[i] <= irq_s[i].
  - Follows the source; W1C and SW_SET have no effect.
- PENDING[i], edge mode, in priority order:
  - set if rise[i] or an SW_SET write with writedata[i]=1;
  - else clear if a PENDING write with writedata[i]=1;
  - else hold.
  - A set and a W1C in the same cycle: set wins, so no event is lost.
- OVERFLOW[i], edge mode only:
  - Sticky set when a set condition occurs while PENDING[i] is already 1 and not being cleared that cycle.
  - Cleared by W1C at address 7; a set in the same cycle wins.
- Switching a bit from edge to level mode: PENDING[i] reloads from irq_s[i] on the next cycle; OVERFLOW[i] holds until cleared.
- ACTIVE = PENDING & MASK.
- irq_out <= |ACTIVE.
- irq_index <= lowest set bit index of ACTIVE; 0 when ACTIVE=0.
- Latency from a source asserting at edge N:
  - irq_s at N+1, PENDING at N+2, irq_out/irq_index at N+3.
  - Level deassertion propagates with the same 3-cycle latency.
- Register map (write = chipselect & ~write_n; reads take effect one cycle later in readdata):
  - 0 PENDING: read; W1C for edge bits.
  - 1 MASK: read/write.
  - 2 EDGE_MODE: read/write.
  - 3 ACTIVE: read-only.
  - 4 HIGHEST: read-only; bit15 = |ACTIVE, bits3:0 = the irq_index value; other bits 0.
  - 5 RAW: read-only irq_s.
  - 6 SW_SET: write-only; reads 0.
  - 7 OVERFLOW: read; W1C.
- readdata <= mux(address) every cycle, independent of chipselect.
- Writes to read-only addresses are ignored.
- A read of PENDING in the same cycle as a W1C returns the pre-clear value.

Test Plan:
- Reset: hold reset_n=0 for 2 cycles with irq_in=8'hFF → readdata=0, irq_out=0; MASK reads 0, EDGE_MODE reads 0.
- Level path: MASK=8'h04; raise irq_in[2] at edge N → irq_out=1 and irq_index=2 at N+3; drop irq_in[2] → irq_out=0 three cycles later.
- Edge capture and W1C: EDGE_MODE=8'h01, MASK=8'h01; one-cycle pulse on irq_in[0] → PENDING=16'h0001, irq_out=1 held; write 16'h0001 to address 0 → irq_out=0 two cycles after the write.
- Priority: MASK=8'hFF; irq_in=8'h28 (level) → irq_index=3, HIGHEST read=16'h8003; clear MASK[3] → irq_index=5, HIGHEST=16'h8005.
- Overflow and collision: EDGE_MODE=8'h02, MASK=8'h02; two pulses on irq_in[1] without clearing → OVERFLOW=16'h0002; next, align a pulse's PENDING-set cycle with a W1C of PENDING → PENDING stays 16'h0002.
- Software trigger and mode switch: EDGE_MODE=8'h10, MASK=8'h10; write 16'h0010 to address 6 → irq_out=1; same write with EDGE_MODE=0 → no effect; then clear EDGE_MODE[4] with irq_in[4]=0 → PENDING[4]=0 next cycle.
